// File: rtl/sigma_mem_pkg.sv
// Shared definitions for the Sigma main-memory arbiter.
//   - mem_state_e : controller states (IDLE, ACCESS, WAIT, DONE)
//   - LANES       : byte lanes per word
//   - WORD_BITS   : memory word width
//   - owner_width : width of a port index (clog2, never below 1)
package sigma_mem_pkg;

  localparam int LANES     = 4;
  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  function automatic int owner_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sigma_rr_arbiter.sv
// Combinational grant selection for the memory arbiter.
//   req_i     : per-port request vector
//   ptr_i     : index of the last granted port (round-robin only)
//   rr_mode_i : 0 = lowest index wins, 1 = search starts at ptr_i+1
//   gnt_o     : one-hot grant
//   idx_o     : encoded index of gnt_o
//   valid_o   : any request present
module sigma_rr_arbiter
  import sigma_mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int OW        = owner_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [OW-1:0]        ptr_i,
  input  logic                 rr_mode_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [OW-1:0]        idx_o,
  output logic                 valid_o
);

  int          cand;
  logic [OW-1:0] cand_idx;
  logic        found;

  // Walk the ports in search order; the first asserted request wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand     = rr_mode_i ? ((int'(ptr_i) + 1 + i) % NUM_PORTS) : i;
      cand_idx = OW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/sigma_mem_arbiter.sv
// Shared Sigma main memory: word-addressed, byte-lane-writable RAM
// arbitrated between NUM_PORTS requesters.
//   clock, reset : system clock, asynchronous active-high reset
//   req   : per-port request, held until ack
//   we    : per-port byte-lane enables (lane 0 = bits 7:0); zero = read
//   addr  : per-port word address (aliases modulo WORD_DEPTH)
//   wdata : per-port write data
//   ack   : one-cycle completion pulse to the granted port
//   rdata : read data, valid in the ack cycle, held otherwise
//   owner : index of current or last granted port
//   busy  : controller not in IDLE
//
// Handshake: a port raises req and holds it with stable we/addr/wdata until
// the grant edge; the request is latched there and later changes are ignored.
// The transaction always completes with a single ack cycle; the requester
// must drop req in that cycle, otherwise it is seen as a new request at the
// next IDLE edge.
module sigma_mem_arbiter
  import sigma_mem_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 17,
  parameter int WORD_DEPTH    = 1024,
  parameter int WAIT_STATES   = 0,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [LANES*NUM_PORTS-1:0]      we,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr,
  input  logic [WORD_BITS*NUM_PORTS-1:0]  wdata,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [WORD_BITS-1:0]            rdata,
  output logic [owner_width(NUM_PORTS)-1:0] owner,
  output logic                            busy
);

  localparam int OW = owner_width(NUM_PORTS);
  localparam int IW = $clog2(WORD_DEPTH);

  mem_state_e           state_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [NUM_PORTS-1:0] ack_q;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        ptr_q;
  logic [IW-1:0]        addr_q;
  logic [LANES-1:0]     we_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WORD_BITS-1:0] rd_buf_q;
  logic [WORD_BITS-1:0] rdata_q;
  logic [3:0]           wait_cnt_q;
  logic                 busy_q;

  logic [WORD_BITS-1:0] mem_q [WORD_DEPTH];

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [OW-1:0]        arb_idx;
  logic                 arb_valid;

  sigma_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .OW        (OW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .rr_mode_i (PRIORITY_MODE != 0),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  // Winner's address; the bits above the RAM index are dropped so that
  // high addresses alias onto the array.
  logic [ADDR_WIDTH-1:0] addr_win;
  logic                  unused_addr_hi;
  assign addr_win       = addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign unused_addr_hi = ^(addr_win & ~ADDR_WIDTH'(WORD_DEPTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= OW'(NUM_PORTS - 1);
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      rd_buf_q   <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q   <= arb_gnt;
            owner_q <= arb_idx;
            ptr_q   <= arb_idx;
            addr_q  <= addr_win[IW-1:0];
            we_q    <= we[arb_idx*LANES +: LANES];
            wdata_q <= wdata[arb_idx*WORD_BITS +: WORD_BITS];
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Without wait states the word goes straight to the output so
          // rdata only changes on entry to DONE.
          if (WAIT_STATES > 0) begin
            rd_buf_q   <= mem_q[addr_q];
            wait_cnt_q <= 4'(WAIT_STATES);
            state_q    <= ST_WAIT;
          end else begin
            rdata_q <= mem_q[addr_q];
            ack_q   <= gnt_q;
            state_q <= ST_DONE;
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            rdata_q <= rd_buf_q;
            ack_q   <= gnt_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array write at the ACCESS edge; the read above sees the old word.
  always_ff @(posedge clock) begin
    if (state_q == ST_ACCESS) begin
      for (int l = 0; l < LANES; l++) begin
        if (we_q[l]) mem_q[addr_q][l*8 +: 8] <= wdata_q[l*8 +: 8];
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Bench for sigma_mem_arbiter: dut_a (no wait states, fixed priority) and
// dut_b (three wait states, round-robin) share clock and reset.
module tb_sigma_mem_arbiter;

  logic        clock;
  logic        reset;

  logic [1:0]  req_a, req_b;
  logic [7:0]  we_a, we_b;
  logic [33:0] addr_a, addr_b;
  logic [63:0] wdata_a, wdata_b;
  logic [1:0]  ack_a, ack_b;
  logic [31:0] rdata_a, rdata_b;
  logic [0:0]  owner_a, owner_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] port_q[$];

  sigma_mem_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(17), .WORD_DEPTH(1024),
    .WAIT_STATES(0), .PRIORITY_MODE(0)
  ) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .owner(owner_a), .busy(busy_a)
  );

  sigma_mem_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(17), .WORD_DEPTH(1024),
    .WAIT_STATES(3), .PRIORITY_MODE(1)
  ) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .owner(owner_b), .busy(busy_b)
  );

  // Clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] get_ack(input int sel);
    if (sel == 0) return ack_a;
    return ack_b;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    if (sel == 0) return rdata_a;
    return rdata_b;
  endfunction

  function automatic logic get_owner(input int sel);
    if (sel == 0) return owner_a[0];
    return owner_b[0];
  endfunction

  function automatic logic get_busy(input int sel);
    if (sel == 0) return busy_a;
    return busy_b;
  endfunction

  function automatic logic [1:0] onehot(input int port);
    logic [1:0] v;
    v = 2'b00;
    v[port] = 1'b1;
    return v;
  endfunction

  // Driver tasks
  task automatic set_port(input int sel, input int port, input logic r, input logic [3:0] w,
                          input logic [16:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req_a[port] = r; we_a[port*4 +: 4] = w; addr_a[port*17 +: 17] = a; wdata_a[port*32 +: 32] = d;
    end else begin
      req_b[port] = r; we_b[port*4 +: 4] = w; addr_b[port*17 +: 17] = a; wdata_b[port*32 +: 32] = d;
    end
  endtask

  // One transaction on one port; expected rdata goes through exp_q.
  task automatic do_txn(input int sel, input int port, input logic [3:0] w, input logic [16:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int ws,
                        input bit drop_early, input bit scramble);
    int edges;
    bit got;
    set_port(sel, port, 1'b1, w, a, d);
    exp_q.push_back(exp_rd);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == 1 && drop_early) set_port(sel, port, 1'b0, w, a, d);
      if (edges == 1 && scramble)   set_port(sel, port, 1'b1, 4'hF, 17'h21, 32'hFFFF0000);
      if (get_ack(sel) != 2'b00) got = 1'b1;
    end
    check_eq("ack_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(edges), 32'(2 + ws));
    check_eq("ack_vec", 32'(get_ack(sel)), 32'(onehot(port)));
    check_eq("owner", 32'(get_owner(sel)), 32'(port));
    check_eq("rdata", get_rdata(sel), exp_q.pop_front());
    set_port(sel, port, 1'b0, 4'h0, 17'h0, 32'h0);
    @(negedge clock);
    check_eq("ack_pulse", 32'(get_ack(sel)), 32'd0);
    check_eq("busy_after", 32'(get_busy(sel)), 32'd0);
  endtask

  // Hold the given requests; expected winners are taken from port_q.
  task automatic contend(input int sel, input logic [1:0] reqs, input int n, input int period);
    int cyc, seen, last;
    logic [31:0] exp_port;
    for (int p = 0; p < 2; p++) set_port(sel, p, reqs[p], 4'h0, 17'h0, 32'h0);
    cyc  = 0;
    seen = 0;
    last = -1;
    while (seen < n && cyc < 200) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (get_ack(sel) != 2'b00) begin
        exp_port = port_q.pop_front();
        check_eq("cont_ack", 32'(get_ack(sel)), 32'(onehot(int'(exp_port))));
        check_eq("cont_owner", 32'(get_owner(sel)), exp_port);
        if (last >= 0) check_eq("cont_period", 32'(cyc - last), 32'(period));
        last = cyc;
        seen++;
        if (seen == n) for (int p = 0; p < 2; p++) set_port(sel, p, 1'b0, 4'h0, 17'h0, 32'h0);
      end
    end
    check_eq("cont_count", 32'(seen), 32'(n));
    repeat (2) @(negedge clock);
  endtask

  task automatic watch_no_ack(input int sel, input int cycles);
    logic [1:0] seen;
    seen = 2'b00;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      seen |= get_ack(sel);
    end
    check_eq("no_ack", 32'(seen), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) @(negedge clock);

    // Reset state
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_ack", 32'(get_ack(s)), 32'd0);
      check_eq("rst_rdata", get_rdata(s), 32'd0);
      check_eq("rst_owner", 32'(get_owner(s)), 32'd0);
      check_eq("rst_busy", 32'(get_busy(s)), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    // Fixed priority: port 0 takes every grant
    repeat (4) port_q.push_back(32'd0);
    contend(0, 2'b11, 4, 3);

    // Round-robin: alternation from port 0, then a lone requester re-granted
    port_q.push_back(32'd0); port_q.push_back(32'd1);
    port_q.push_back(32'd0); port_q.push_back(32'd1);
    contend(1, 2'b11, 4, 6);
    port_q.push_back(32'd1); port_q.push_back(32'd1);
    contend(1, 2'b10, 2, 6);

    // Plain write then read
    do_txn(0, 0, 4'hF, 17'h10, 32'h12345678, 32'h0, 0, 1'b0, 1'b0);
    do_txn(0, 0, 4'h0, 17'h10, 32'h0, 32'h12345678, 0, 1'b0, 1'b0);

    // Byte lanes: write returns the old word, merge visible afterwards
    do_txn(0, 1, 4'hF, 17'h5, 32'hAABBCCDD, 32'h0, 0, 1'b0, 1'b0);
    do_txn(0, 1, 4'b0101, 17'h5, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, 1'b0);
    do_txn(0, 0, 4'h0, 17'h5, 32'h0, 32'hAA22CC44, 0, 1'b0, 1'b0);

    // Idle port 1 with write enables, granted port changed after latch
    set_port(0, 1, 1'b0, 4'hF, 17'h21, 32'hFFFFFFFF);
    do_txn(0, 0, 4'hF, 17'h20, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b1);
    set_port(0, 1, 1'b0, 4'h0, 17'h0, 32'h0);
    do_txn(0, 0, 4'h0, 17'h20, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    do_txn(0, 1, 4'h0, 17'h21, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // Wait states, address aliasing, early req drop
    do_txn(1, 0, 4'hF, 17'h0, 32'h0BADBEEF, 32'h0, 3, 1'b0, 1'b0);
    do_txn(1, 1, 4'h0, 17'h400, 32'h0, 32'h0BADBEEF, 3, 1'b0, 1'b0);
    do_txn(1, 0, 4'h0, 17'h1400, 32'h0, 32'h0BADBEEF, 3, 1'b1, 1'b0);

    // Reset before the ACCESS edge: write must not land
    do_txn(1, 0, 4'hF, 17'h8, 32'h13579BDF, 32'h0, 3, 1'b0, 1'b0);
    set_port(1, 1, 1'b1, 4'hF, 17'h8, 32'h55555555);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    set_port(1, 1, 1'b0, 4'h0, 17'h0, 32'h0);
    #1;
    check_eq("rst1_busy", 32'(busy_b), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    watch_no_ack(1, 8);
    do_txn(1, 0, 4'h0, 17'h8, 32'h0, 32'h13579BDF, 3, 1'b0, 1'b0);

    // Reset while waiting after the write: write persists, outputs clear at once
    set_port(1, 1, 1'b1, 4'hF, 17'h7, 32'hCAFEF00D);
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    check_eq("pre_rst_busy", 32'(busy_b), 32'd1);
    check_eq("pre_rst_owner", 32'(owner_b), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst2_ack", 32'(ack_b), 32'd0);
    check_eq("rst2_rdata", rdata_b, 32'd0);
    check_eq("rst2_owner", 32'(owner_b), 32'd0);
    check_eq("rst2_busy", 32'(busy_b), 32'd0);
    set_port(1, 1, 1'b0, 4'h0, 17'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    watch_no_ack(1, 8);
    do_txn(1, 0, 4'h0, 17'h7, 32'h0, 32'hCAFEF00D, 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
